debug_dump_tx: RTL and testbench
================================

// Module: debug_dump_tx
// PURPOSE
//  Transmit side of the debug unit's UART link: serialises PC, register-bank and data-memory
//  dumps into bytes for the UART TX, least-significant byte first, the inverse of the host's
//  4-byte LSB-first instruction upload. Sits between the debug-unit command FSM and uart_tx.
//  Pulls each word through a synchronous read port and paces bytes on the TX done tick.
// PARAMETERS
//  NB_DATA   32   word width of register bank / data memory / PC
//  NB_BYTE   8    UART byte width
//  NB_ADDR   7    read-address width (must hold max(N_REGS,N_MEM)-1)
//  N_REGS    32   words in a register-bank dump
//  N_MEM     128  words in a data-memory dump
//  PC_BYTES  1    bytes of i_pc sent in a PC dump (low bytes, LSB first), 1..NB_DATA/NB_BYTE
// PORTS
//  i_clock         in   1        system clock
//  i_reset         in   1        synchronous, active-high reset
//  i_start         in   1        one-cycle request; sampled only in IDLE
//  i_sel           in   2        0=PC, 1=register bank, 2=data memory, 3=reserved
//  i_pc            in   NB_DATA  current PC value
//  i_br_data       in   NB_DATA  register-bank read data, valid 1 cycle after o_rd_addr
//  i_mem_data      in   NB_DATA  data-memory read data, valid 1 cycle after o_rd_addr
//  i_tx_done_tick  in   1        uart_tx finished current byte
//  o_rd_addr       out  NB_ADDR  word address for BR/MEM read
//  o_br_rd_en      out  1        high while reading the register bank
//  o_mem_rd_en     out  1        high while reading data memory
//  o_tx_start      out  1        one-cycle pulse: send o_tx_data
//  o_tx_data       out  NB_BYTE  byte to send; stable from o_tx_start until i_tx_done_tick
//  o_busy          out  1        high from the cycle after accepted i_start until o_done
//  o_done          out  1        one-cycle pulse after the last byte's done tick
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; word/byte counters and shift register 0.
//  - FSM: IDLE -> READ -> LOAD -> SEND -> WAIT -> {SEND | READ | DONE} -> IDLE.
//  - IDLE: i_start & i_sel!=3 latches i_sel, clears counters, goes to READ. i_sel==3 is ignored (stays IDLE).
//  - READ (1 cycle): o_rd_addr=word count; rd_en for the selected source; PC dump skips straight to LOAD.
//  - LOAD: shift register <= i_br_data / i_mem_data / i_pc; byte count cleared.
//  - SEND (1 cycle): o_tx_start=1, o_tx_data=shift[NB_BYTE-1:0]; -> WAIT.
//  - WAIT: hold o_tx_data; on i_tx_done_tick shift right by NB_BYTE, byte count++;
//    more bytes in word -> SEND; else more words -> READ (word count++); else -> DONE.
//    Bytes/word: 4 for BR/MEM, PC_BYTES for PC. Words: 1 / N_REGS / N_MEM.
//  - DONE: o_done=1 for one cycle, o_busy drops the same cycle; -> IDLE.
//  - i_tx_done_tick outside WAIT is ignored; i_start while busy is ignored (no queueing).
//  - Word count wraps never: last address is N-1, checked before increment.
//  - Latency: accepted i_start -> first o_tx_start = 3 cycles (READ, LOAD, SEND).
//  - Totals: PC=PC_BYTES bytes, BR=4*N_REGS (128), MEM=4*N_MEM (512).
//  - Reset mid-dump: abandons transfer next edge, no o_done, outputs to reset values.
// CONFIGURATION
//  DEBUG_DUMP_CHECKSUM_EN defined: after the final data byte, one extra byte is sent =
//   XOR of all data bytes of that dump (same SEND/WAIT handshake); o_done follows its done tick.
//   The accumulator clears on accepted i_start.
//  Undefined: no checksum byte; byte totals exactly as above.
// TESTING
//  1 PC dump: i_pc=0x0000002C, sel=0, start -> one o_tx_start, data 0x2C at cycle +3; done tick -> o_done next cycle.
//  2 BR dump: reg k=0x01020300+k -> 128 bytes; reg 0 sends 00,03,02,01; o_rd_addr walks 0..31; one o_done.
//  3 MEM dump: mem k=k -> 512 bytes, last word addr 127 sends 7F,00,00,00; o_mem_rd_en only during READ.
//  4 Pacing: done tick delayed 50 cycles -> o_tx_data held, no extra o_tx_start; done tick in IDLE
//    and start/sel=3 while busy -> no effect.
//  5 Reset after 10th byte of BR dump -> next cycle all outputs 0, no o_done; new PC dump then correct.
//  6 With DEBUG_DUMP_CHECKSUM_EN: PC 0x2C -> bytes 2C,2C; BR reg k=k -> 129th byte = 0x00.

Source files
------------

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: transmit side of the debug UART link. Serialises a PC,
// register-bank or data-memory dump into bytes for uart_tx, least-significant
// byte first, reading each word through a synchronous read port and pacing
// bytes on the uart_tx done tick.
// Optional feature macro: DEBUG_DUMP_CHECKSUM_EN -- appends one byte equal to
// the XOR of all data bytes of the dump before o_done.
module debug_dump_tx #(
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_ADDR  = 7,
  parameter int N_REGS   = 32,
  parameter int N_MEM    = 128,
  parameter int PC_BYTES = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_sel,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_br_data,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_tx_done_tick,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic               o_br_rd_en,
  output logic               o_mem_rd_en,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_done
);
  localparam int BPW  = NB_DATA / NB_BYTE;
  localparam int BC_W = $clog2(BPW) + 1;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sel;
  logic [NB_ADDR-1:0]  r_word_cnt;
  logic [BC_W-1:0]     r_byte_cnt;
  logic [NB_DATA-1:0]  r_shift;

  logic                w_accept;
  logic                w_last_byte;
  logic                w_last_word;
  logic                w_ck_pending;
  logic [BC_W-1:0]     w_last_byte_idx;
  logic [NB_ADDR-1:0]  w_last_addr;
  logic [NB_DATA-1:0]  w_load_word;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_sel != 2'd3);

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]  r_ck_acc;
  logic                r_ck_phase;
  logic [NB_BYTE-1:0]  w_ck_byte;

  assign w_ck_byte    = r_ck_acc ^ r_shift[NB_BYTE-1:0];
  assign w_ck_pending = !r_ck_phase;
`else
  assign w_ck_pending = 1'b0;
`endif

  // Per-source geometry: bytes per word and address of the final word.
  always_comb begin
    w_last_byte_idx = BC_W'(BPW - 1);
    w_last_addr     = '0;
    w_load_word     = '0;
    case (r_sel)
      SEL_PC: begin
        w_last_byte_idx = BC_W'(PC_BYTES - 1);
        w_load_word     = i_pc;
      end
      SEL_BR: begin
        w_last_addr = NB_ADDR'(N_REGS - 1);
        w_load_word = i_br_data;
      end
      SEL_MEM: begin
        w_last_addr = NB_ADDR'(N_MEM - 1);
        w_load_word = i_mem_data;
      end
      default: ;
    endcase
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // While the checksum byte is in flight it is both the last byte and word.
  assign w_last_byte = r_ck_phase || (r_byte_cnt == w_last_byte_idx);
  assign w_last_word = r_ck_phase || (r_word_cnt == w_last_addr);
`else
  assign w_last_byte = (r_byte_cnt == w_last_byte_idx);
  assign w_last_word = (r_word_cnt == w_last_addr);
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_next      = r_state;
    o_rd_addr   = '0;
    o_br_rd_en  = 1'b0;
    o_mem_rd_en = 1'b0;
    o_tx_start  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_tx_data   = r_shift[NB_BYTE-1:0];
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_READ;
      S_READ: begin
        o_busy      = 1'b1;
        o_br_rd_en  = (r_sel == SEL_BR);
        o_mem_rd_en = (r_sel == SEL_MEM);
        if (r_sel != SEL_PC) o_rd_addr = r_word_cnt;
        w_next = S_LOAD;
      end
      S_LOAD: begin
        o_busy = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_tx_done_tick) begin
          if (!w_last_byte)      w_next = S_SEND;
          else if (!w_last_word) w_next = S_READ;
          else if (w_ck_pending) w_next = S_SEND;
          else                   w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: source latch, word/byte counters, byte shift register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sel      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      r_ck_acc   <= '0;
      r_ck_phase <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sel      <= i_sel;
          r_word_cnt <= '0;
          r_byte_cnt <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          r_ck_acc   <= '0;
          r_ck_phase <= 1'b0;
`endif
        end
        S_LOAD: begin
          r_shift    <= w_load_word;
          r_byte_cnt <= '0;
        end
        S_WAIT: if (i_tx_done_tick) begin
          r_shift    <= r_shift >> NB_BYTE;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (w_last_byte && !w_last_word) r_word_cnt <= r_word_cnt + 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          r_ck_acc <= w_ck_byte;
          if (w_last_byte && w_last_word && !r_ck_phase) begin
            r_shift    <= NB_DATA'(w_ck_byte);
            r_ck_phase <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_dump_tx.sv
// Self-checking bench for debug_dump_tx: scoreboard of expected bytes and
// read addresses, a randomly paced uart_tx responder, and synchronous
// register-bank / data-memory models.
module tb_debug_dump_tx;
  localparam int NB_DATA  = 32;
  localparam int NB_BYTE  = 8;
  localparam int NB_ADDR  = 7;
  localparam int N_REGS   = 32;
  localparam int N_MEM    = 128;
  localparam int PC_BYTES = 1;

  logic               clk;
  logic               i_reset, i_start, i_tx_done_tick;
  logic [1:0]         i_sel;
  logic [NB_DATA-1:0] i_pc, i_br_data, i_mem_data;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic               o_br_rd_en, o_mem_rd_en, o_tx_start, o_busy, o_done;
  logic [NB_BYTE-1:0] o_tx_data;

  logic [31:0] regs [N_REGS];
  logic [31:0] mem  [N_MEM];
  logic [7:0]  exp_q [$];
  int          addr_q [$];
  int          cur_sel;
  int          n_tests, n_fail;
  int          done_cnt, byte_cnt;
  int          min_delay, max_delay;
  bit          idle_tick_req;

  debug_dump_tx #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR),
    .N_REGS(N_REGS), .N_MEM(N_MEM), .PC_BYTES(PC_BYTES)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_sel(i_sel),
    .i_pc(i_pc), .i_br_data(i_br_data), .i_mem_data(i_mem_data),
    .i_tx_done_tick(i_tx_done_tick), .o_rd_addr(o_rd_addr),
    .o_br_rd_en(o_br_rd_en), .o_mem_rd_en(o_mem_rd_en),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a list of words, each sent as its low bytes
  // LSB first; optionally followed by the XOR of every byte sent.
  task automatic push_dump(input int sel);
    int nw, nb;
    logic [31:0] word;
    logic [7:0]  b, x;
    nw = (sel == 0) ? 1 : (sel == 1) ? N_REGS : N_MEM;
    nb = (sel == 0) ? PC_BYTES : NB_DATA / NB_BYTE;
    x  = 8'h00;
    for (int w = 0; w < nw; w++) begin
      word = (sel == 0) ? i_pc : (sel == 1) ? regs[w] : mem[w];
      if (sel != 0) addr_q.push_back(w);
      for (int k = 0; k < nb; k++) begin
        b = 8'((word >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Synchronous read ports: data valid only in the cycle after the address.
  initial begin
    int br_a, mem_a;
    bit br_p, mem_p;
    br_p = 0; mem_p = 0; br_a = 0; mem_a = 0;
    i_br_data = '0; i_mem_data = '0;
    forever begin
      @(negedge clk);
      if (br_p) begin i_br_data = regs[br_a]; br_p = 0; end
      else i_br_data = $urandom;
      if (mem_p) begin i_mem_data = mem[mem_a]; mem_p = 0; end
      else i_mem_data = $urandom;
      if (o_br_rd_en)  begin br_p = 1;  br_a  = int'(o_rd_addr) % N_REGS; end
      if (o_mem_rd_en) begin mem_p = 1; mem_a = int'(o_rd_addr) % N_MEM; end
    end
  end

  // uart_tx stand-in: holds each byte for a random time, then one done tick.
  initial begin
    bit active;
    int cnt;
    logic [7:0] held;
    active = 0; cnt = 0; held = '0;
    i_tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done_tick = 1'b0;
      if (!o_busy) begin
        active = 0;
        if (idle_tick_req) begin i_tx_done_tick = 1'b1; idle_tick_req = 0; end
      end else if (active) begin
        chk("no_extra_start", 32'(o_tx_start), 32'd0);
        chk("tx_data_hold", 32'(o_tx_data), 32'(held));
        if (cnt == 0) begin i_tx_done_tick = 1'b1; active = 0; end
        else cnt--;
      end else if (o_tx_start) begin
        active = 1;
        held   = o_tx_data;
        cnt    = $urandom_range(max_delay, min_delay);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT emits a byte, read or done.
  initial begin
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        if (o_tx_start) begin
          byte_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_byte_unexpected: got 0x%0h expected none", o_tx_data);
          end else chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
        if (o_br_rd_en || o_mem_rd_en) begin
          chk("rd_en_src", 32'({o_mem_rd_en, o_br_rd_en}), (cur_sel == 1) ? 32'd1 : 32'd2);
          if (addr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rd_addr_unexpected: got %0d expected none", o_rd_addr);
          end else chk("rd_addr", 32'(o_rd_addr), 32'(addr_q.pop_front()));
        end
        if (o_done) begin
          done_cnt++;
          chk("done_busy_low", 32'(o_busy), 32'd0);
          chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
    chk({tag, "_br_rd_en"}, 32'(o_br_rd_en), 32'd0);
    chk({tag, "_mem_rd_en"}, 32'(o_mem_rd_en), 32'd0);
    chk({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  task automatic issue_start(input int sel);
    cur_sel = sel;
    push_dump(sel);
    i_start = 1'b1; i_sel = 2'(sel);
    @(negedge clk);
    i_start = 1'b0; i_sel = 2'($urandom_range(0, 3));
    chk("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  task automatic run_dump(input int sel);
    int d0;
    d0 = done_cnt;
    issue_start(sel);
    @(negedge clk);
    @(negedge clk);
    chk("latency3_tx_start", 32'(o_tx_start), 32'd1);
    // A start request while busy must be ignored.
    i_start = 1'b1; i_sel = 2'($urandom_range(0, 3));
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
    chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
    repeat (3) @(negedge clk);
    chk("done_single", 32'(done_cnt), 32'(d0 + 1));
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);
  endtask

  task automatic randomize_contents();
    for (int k = 0; k < N_REGS; k++) regs[k] = $urandom;
    for (int k = 0; k < N_MEM; k++)  mem[k]  = $urandom;
    i_pc = $urandom;
  endtask

  initial begin
    int b0, d0, sel;
    n_tests = 0; n_fail = 0; done_cnt = 0; byte_cnt = 0;
    min_delay = 0; max_delay = 3; idle_tick_req = 0; cur_sel = 0;
    i_reset = 1'b1; i_start = 1'b0; i_sel = 2'd0; i_pc = '0;
    for (int k = 0; k < N_REGS; k++) regs[k] = 32'h01020300 + k;
    for (int k = 0; k < N_MEM; k++)  mem[k]  = k;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    i_reset = 1'b0;
    @(negedge clk);

    // Stray done tick and a reserved-select start while idle do nothing.
    b0 = byte_cnt;
    idle_tick_req = 1;
    i_start = 1'b1; i_sel = 2'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_sel3_busy", 32'(o_busy), 32'd0);
      chk("idle_sel3_tx_start", 32'(o_tx_start), 32'd0);
    end
    chk("idle_no_bytes", 32'(byte_cnt), 32'(b0));

    // PC dump with a slow uart_tx.
    i_pc = 32'h0000002C;
    min_delay = 50; max_delay = 50;
    run_dump(0);
    min_delay = 0; max_delay = 3;

    run_dump(1);
    run_dump(2);

    repeat (4) begin
      randomize_contents();
      sel = $urandom_range(0, 2);
      run_dump(sel);
    end

    // Reset in the middle of a register-bank dump.
    randomize_contents();
    d0 = done_cnt;
    b0 = byte_cnt;
    issue_start(1);
    for (int c = 0; c < 2000 && byte_cnt < b0 + 10; c++) @(negedge clk);
    chk("ten_bytes_before_reset", 32'(byte_cnt >= b0 + 10), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    i_reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt), 32'(d0));
    chk("midreset_idle", 32'(o_busy), 32'd0);

    i_pc = $urandom;
    run_dump(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
